// File: rtl/_shift8_rx_pkg.sv
// Shared types and sizing constants for the serial-to-parallel receiver.
// Holds the FSM state encoding and the counter-width helper.
package _shift8_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 8;

  // The bit counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W_DEFAULT = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/_shreg8_r.sv
// Parallel-out shift register with shift enable and direction select.
// lsb_first=0 pushes new bits in at bit 0 so the first bit ends up in the MSB.
module _shreg8_r #(
  parameter int WIDTH = _shift8_rx_pkg::WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             lsb_first,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours; blocking here would chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (shift_en) begin
      if (lsb_first) q <= {din, q[WIDTH-1:1]};
      else           q <= {q[WIDTH-2:0], din};
    end
  end

endmodule

// File: rtl/_shift8_rx.sv
// Framed serial receiver: start arms a frame, WIDTH qualified bits assemble
// a word that is held under valid/ready until consumed.
module _shift8_rx
  import _shift8_rx_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovr_d;
  logic             shift_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      overrun <= ovr_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    ovr_d    = overrun;
    shift_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = '0;
          state_d = RECV;
        end
      end
      RECV: begin
        // A restart wins over the bit offered in the same cycle.
        if (start) begin
          cnt_d = '0;
        end else if (sin_valid) begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FULL;
        end
      end
      FULL: begin
        if (sin_valid) ovr_d = 1'b1;
        if (dout_ready) begin
          if (start) begin
            cnt_d   = '0;
            state_d = RECV;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  _shreg8_r #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (shift_en),
    .lsb_first (LSB_FIRST),
    .din       (sin),
    .q         (dout)
  );

  assign dout_valid = (state_q == FULL);
  assign busy       = (state_q == RECV);

endmodule

// File: tb/tb__shift8_rx.sv
// Directed bench for _shift8_rx: an MSB-first and an LSB-first instance share
// the same stimulus; expected words are hand-computed or bit-reversed here.
module tb__shift8_rx;

  logic       clk = 1'b0;
  logic       reset, start, sin, sin_valid, dout_ready;
  logic [7:0] dout0, dout1;
  logic       dout_valid0, dout_valid1, busy0, busy1, overrun0, overrun1;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  _shift8_rx #(.WIDTH(8), .LSB_FIRST(1'b0)) dut0 (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .dout       (dout0),
    .dout_valid (dout_valid0),
    .dout_ready (dout_ready),
    .busy       (busy0),
    .overrun    (overrun0)
  );

  _shift8_rx #(.WIDTH(8), .LSB_FIRST(1'b1)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .dout       (dout1),
    .dout_valid (dout_valid1),
    .dout_ready (dout_ready),
    .busy       (busy1),
    .overrun    (overrun1)
  );

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends n bits of v, starting at v[7] and walking down, with gap idle cycles between bits.
  task automatic send_bits(input logic [7:0] v, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        sin_valid = 1'b0;
        repeat (gap) tick();
      end
      sin       = v[7-i];
      sin_valid = 1'b1;
      tick();
    end
    sin_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic handshake();
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sin = 1'b0; sin_valid = 1'b0; dout_ready = 1'b0;
    #3;
    check("rst_dout0",     dout0,                8'h00);
    check("rst_dout1",     dout1,                8'h00);
    check("rst_flags0",    {5'b0, dout_valid0, busy0, overrun0}, 8'h00);
    check("rst_flags1",    {5'b0, dout_valid1, busy1, overrun1}, 8'h00);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Basic frame 1,0,1,0,0,1,0,1 -> A5 in both bit orders.
    pulse_start();
    check("start_busy", {7'b0, busy0}, 8'h01);
    send_bits(8'hA5, 7, 0);
    check("a5_not_yet_valid", {7'b0, dout_valid0}, 8'h00);
    send_bits({8'hA5 << 7}, 1, 0);
    check("a5_valid",  {7'b0, dout_valid0}, 8'h01);
    check("a5_busy",   {7'b0, busy0},       8'h00);
    check("a5_dout0",  dout0,               8'hA5);
    check("a5_dout1",  dout1,               8'hA5);
    handshake();
    check("hs_idle", {6'b0, dout_valid0, busy0}, 8'h00);

    // sin_valid in IDLE is ignored.
    sin = 1'b1; sin_valid = 1'b1;
    tick(); tick();
    sin_valid = 1'b0;
    check("idle_sin_state", {6'b0, dout_valid0, busy0}, 8'h00);
    check("idle_no_ovr",    {7'b0, overrun0},           8'h00);

    // 1,1,0,0,0,0,0,0 -> C0 MSB-first, 03 LSB-first.
    pulse_start();
    send_bits(8'hC0, 8, 0);
    check("c0_dout0", dout0, 8'hC0);
    check("c0_dout1", dout1, 8'h03);
    handshake();

    // Three-cycle gaps between bits; valid follows the last bit only.
    pulse_start();
    send_bits(8'h96, 7, 3);
    sin_valid = 1'b0;
    repeat (3) tick();
    check("gap_not_yet_valid", {6'b0, dout_valid0, busy0}, 8'h01);
    send_bits({8'h96 << 7}, 1, 0);
    check("gap_valid", {7'b0, dout_valid0}, 8'h01);
    check("gap_dout0", dout0, 8'h96);
    check("gap_dout1", dout1, rev8(8'h96));

    // Overrun: sin_valid pulses while FULL and unconsumed.
    for (int i = 0; i < 5; i++) begin
      sin       = ~sin;
      sin_valid = (i % 2 == 0);
      tick();
    end
    sin_valid = 1'b0;
    check("ovr_dout_held", dout0, 8'h96);
    check("ovr_still_valid", {7'b0, dout_valid0}, 8'h01);
    check("ovr_set", {7'b0, overrun0}, 8'h01);
    handshake();
    check("ovr_sticky_after_hs", {7'b0, overrun0}, 8'h01);

    // Abort after 4 bits; the bit offered with the restart is discarded.
    pulse_start();
    send_bits(8'hF0, 4, 0);
    start = 1'b1; sin = 1'b0; sin_valid = 1'b1;
    tick();
    start = 1'b0; sin_valid = 1'b0;
    check("abort_busy", {6'b0, dout_valid0, busy0}, 8'h01);
    send_bits(8'h3C, 7, 0);
    check("abort_not_full", {7'b0, dout_valid0}, 8'h00);
    send_bits({8'h3C << 7}, 1, 0);
    check("abort_dout0", dout0, 8'h3C);
    check("abort_dout1", dout1, rev8(8'h3C));

    // Start ignored in FULL without a handshake.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("full_start_ignored", {6'b0, dout_valid0, busy0}, 8'h02);

    // Handshake with start goes straight back to RECV.
    dout_ready = 1'b1; start = 1'b1;
    tick();
    dout_ready = 1'b0; start = 1'b0;
    check("hs_start_recv", {6'b0, dout_valid0, busy0}, 8'h01);
    send_bits(8'hFF, 8, 0);
    check("ff_dout0", dout0, 8'hFF);
    check("ff_dout1", dout1, 8'hFF);
    check("ff_valid", {7'b0, dout_valid0}, 8'h01);
    check("ff_ovr_sticky", {7'b0, overrun0}, 8'h01);

    // Asynchronous reset in the middle of a frame.
    handshake();
    pulse_start();
    send_bits(8'hF8, 5, 0);
    #2 reset = 1'b1;
    #1;
    check("arst_dout0",  dout0, 8'h00);
    check("arst_dout1",  dout1, 8'h00);
    check("arst_flags0", {5'b0, dout_valid0, busy0, overrun0}, 8'h00);
    check("arst_flags1", {5'b0, dout_valid1, busy1, overrun1}, 8'h00);
    #2 reset = 1'b0;
    tick();
    pulse_start();
    send_bits(8'h81, 8, 0);
    check("post_rst_dout0", dout0, 8'h81);
    check("post_rst_dout1", dout1, 8'h81);
    check("post_rst_valid", {6'b0, dout_valid0, overrun0}, 8'h02);
    handshake();
    check("post_rst_idle", {6'b0, dout_valid0, busy0}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no completion, expected finish");
    $fatal(1, "timeout");
  end

endmodule
